// File: rtl/iir_sched_pkg.sv
// Shared widths, FSM state encoding and result-narrowing helpers for the
// IIR MAC scheduler.
package iir_sched_pkg;
    localparam int DW = 4;
    localparam int PW = 8;

    typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

    function automatic logic fits4(input logic [DW:0] sum5);
        return sum5[DW] == sum5[DW-1];
    endfunction

    function automatic logic [DW-1:0] sat4(input logic [DW:0] sum5);
        if (fits4(sum5))
            return sum5[DW-1:0];
        return sum5[DW] ? 4'b1000 : 4'b0111;
    endfunction
endpackage

// File: rtl/iir_state_bank.sv
// Per-channel coefficient and y_prev register file; the state write port
// overrides a simultaneous clear of the same channel.
module iir_state_bank
    import iir_sched_pkg::*;
#(
    parameter int CH  = 4,
    parameter int CHW = $clog2(CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_cfg_we,
    input  logic           i_cfg_clr,
    input  logic [CHW-1:0] i_cfg_ch,
    input  logic [DW-1:0]  i_cfg_coef,
    input  logic           i_st_we,
    input  logic [CHW-1:0] i_st_ch,
    input  logic [DW-1:0]  i_st_y,
    input  logic [CHW-1:0] i_rd_ch,
    output logic [DW-1:0]  o_rd_coef,
    output logic [DW-1:0]  o_rd_y
);
    logic [DW-1:0] r_coef [CH];
    logic [DW-1:0] r_y    [CH];
    logic          w_rd_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_coef[i] <= '0;
                r_y[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (i_cfg_we && int'(i_cfg_ch) == i)
                    r_coef[i] <= i_cfg_coef;
                if (i_st_we && int'(i_st_ch) == i)
                    r_y[i] <= i_st_y;
                else if (i_cfg_clr && int'(i_cfg_ch) == i)
                    r_y[i] <= '0;
            end
        end
    end

    assign w_rd_ok   = int'(i_rd_ch) < CH;
    assign o_rd_coef = w_rd_ok ? r_coef[i_rd_ch] : '0;
    assign o_rd_y    = w_rd_ok ? r_y[i_rd_ch]    : '0;
endmodule

// File: rtl/iir_mac_scheduler.sv
// Time-shares one external 4x4 signed multiplier across CH first-order IIR
// channels. Define IIR_SAT_EN to saturate results instead of wrapping.
module iir_mac_scheduler
    import iir_sched_pkg::*;
#(
    parameter int CH   = 4,
    parameter int CHW  = $clog2(CH),
    parameter int FRAC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic [DW-1:0]  in_x,
    input  logic           cfg_we,
    input  logic           cfg_clr,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [DW-1:0]  cfg_coef,
    output logic [DW-1:0]  mul_a,
    output logic [DW-1:0]  mul_b,
    input  logic [PW-1:0]  mul_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic [DW-1:0]  out_y,
    output logic           busy,
    output logic           ovf
);
    state_t         r_state;
    logic [CHW-1:0] r_ch;
    logic [DW-1:0]  r_x;
    logic [PW-1:0]  r_p;
    logic [DW-1:0]  r_mul_a;
    logic [DW-1:0]  r_mul_b;
    logic           r_out_valid;
    logic [CHW-1:0] r_out_ch;
    logic [DW-1:0]  r_out_y;
    logic           r_ovf;
    logic           r_in_ready;
    logic           r_busy;

    logic [DW-1:0]  w_coef;
    logic [DW-1:0]  w_y;
    logic [DW-1:0]  w_a_next;
    logic [DW-1:0]  w_b_next;
    logic [PW-1:0]  w_p_sh;
    logic [DW:0]    w_sum;
    logic [DW-1:0]  w_res;
    logic           w_in_rng;
    logic           w_cfg_hit;
    logic           w_st_we;
    logic           w_unused;

    iir_state_bank #(.CH(CH), .CHW(CHW)) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cfg_we   (cfg_we),
        .i_cfg_clr  (cfg_clr),
        .i_cfg_ch   (cfg_ch),
        .i_cfg_coef (cfg_coef),
        .i_st_we    (w_st_we),
        .i_st_ch    (r_ch),
        .i_st_y     (w_res),
        .i_rd_ch    (in_ch),
        .o_rd_coef  (w_coef),
        .o_rd_y     (w_y)
    );

    // Operands are captured at accept; forward a same-edge config write so
    // the MUL cycle sees the value the bank will hold.
    assign w_in_rng  = int'(in_ch) < CH;
    assign w_cfg_hit = cfg_ch == in_ch;
    assign w_a_next  = (cfg_we && w_cfg_hit) ? cfg_coef : w_coef;
    assign w_b_next  = (cfg_clr && w_cfg_hit) ? '0 : w_y;

    assign w_p_sh   = $signed(r_p) >>> FRAC;
    assign w_sum    = {r_x[DW-1], r_x} + w_p_sh[DW:0];
    assign w_unused = ^w_p_sh[PW-1:DW+1];
    assign w_st_we  = (r_state == ACC);

`ifdef IIR_SAT_EN
    assign w_res = sat4(w_sum);
`else
    assign w_res = w_sum[DW-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_x         <= '0;
            r_p         <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_y     <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Out-of-range channels are consumed and silently dropped.
                    if (in_valid && w_in_rng) begin
                        r_ch       <= in_ch;
                        r_x        <= in_x;
                        r_mul_a    <= w_a_next;
                        r_mul_b    <= w_b_next;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= MUL;
                    end
                end
                MUL: begin
                    r_p     <= mul_p;
                    r_state <= ACC;
                end
                ACC: begin
                    r_out_y     <= w_res;
                    r_out_ch    <= r_ch;
                    r_out_valid <= 1'b1;
                    if (!fits4(w_sum))
                        r_ovf <= 1'b1;
                    r_state <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_mul_a     <= '0;
                        r_mul_b     <= '0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_y     = r_out_y;
    assign busy      = r_busy;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_iir_mac_scheduler.sv
// Directed bench for iir_mac_scheduler with a combinational multiplier model
// and a scoreboard of expected (channel, result) pairs.
module tb_iir_mac_scheduler;
    localparam int CH  = 4;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [CHW-1:0] in_ch = '0;
    logic [3:0]     in_x = '0;
    logic           cfg_we = 1'b0;
    logic           cfg_clr = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [3:0]     cfg_coef = '0;
    logic [3:0]     mul_a;
    logic [3:0]     mul_b;
    logic [7:0]     mul_p;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [CHW-1:0] out_ch;
    logic [3:0]     out_y;
    logic           busy;
    logic           ovf;

    typedef struct {
        int ch;
        int y;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    iir_mac_scheduler #(.CH(CH), .CHW(CHW), .FRAC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_x      (in_x),
        .cfg_we    (cfg_we),
        .cfg_clr   (cfg_clr),
        .cfg_ch    (cfg_ch),
        .cfg_coef  (cfg_coef),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_y     (out_y),
        .busy      (busy),
        .ovf       (ovf)
    );

    // External signed multiplier
    assign mul_p = $signed(mul_a) * $signed(mul_b);

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int s4(input logic [3:0] v);
        return int'($signed(v));
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int ch, input int coef, input bit we, input bit clr);
        cfg_we   = we;
        cfg_clr  = clr;
        cfg_ch   = CHW'(ch);
        cfg_coef = 4'(coef);
        @(negedge clk);
        cfg_we  = 1'b0;
        cfg_clr = 1'b0;
    endtask

    // Drive one sample; returns on the negedge inside MUL.
    task automatic accept(input int ch, input int x);
        in_valid = 1'b1;
        in_ch    = CHW'(ch);
        in_x     = 4'(x);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_mul", int'(busy), 1);
        check("in_ready_mul", int'(in_ready), 0);
    endtask

    // Wait (bounded) for out_valid, check latency, pop and compare.
    task automatic wait_out(input int exp_lat);
        int   n;
        exp_t e;
        n = 0;
        while (out_valid !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, exp_lat);
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 0, 1);
            end else begin
                e = sb.pop_front();
                check("out_y", s4(out_y), e.y);
                check("out_ch", int'(out_ch), e.ch);
            end
        end
    endtask

    task automatic sample(input int ch, input int x, input int ey, input int ea, input int eb);
        exp_t e;
        e.ch = ch;
        e.y  = ey;
        sb.push_back(e);
        accept(ch, x);
        check("mul_a", s4(mul_a), ea);
        check("mul_b", s4(mul_b), eb);
        wait_out(2);
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_mul_a", int'(mul_a), 0);
    endtask

    initial begin
        exp_t e;
        int   hold_y;
        int   hold_ch;
        int   ovf_exp_y;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_mul_b", int'(mul_b), 0);
        check("rst_out_y", int'(out_y), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted in MUL
        cfg(0, 3, 1'b1, 1'b0);
        accept(0, 5);
        check("pre_rst_mul_a", s4(mul_a), 3);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_mul_a", int'(mul_a), 0);
        check("midrst_mul_b", int'(mul_b), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_no_out", int'(out_valid), 0);

        // ch0 coef 0.5, x=4 repeated
        cfg(0, 2, 1'b1, 1'b0);
        sample(0, 4, 4, 2, 0);
        sample(0, 4, 6, 2, 4);
        sample(0, 4, 7, 2, 6);
        sample(0, 4, 7, 2, 7);
        check("ovf_still_0", int'(ovf), 0);

        // ch1 overflow: 4 + (7*4)>>>2 = 11
`ifdef IIR_SAT_EN
        ovf_exp_y = 7;
`else
        ovf_exp_y = -5;
`endif
        cfg(1, 7, 1'b1, 1'b0);
        sample(1, 4, 4, 7, 0);
        sample(1, 4, ovf_exp_y, 7, 4);
        check("ovf_set", int'(ovf), 1);

        // Backpressure hold on ch3 (coef 0)
        cfg(3, 0, 1'b1, 1'b0);
        out_ready = 1'b0;
        e.ch = 3;
        e.y  = 2;
        sb.push_back(e);
        accept(3, 2);
        wait_out(2);
        hold_y  = int'(out_y);
        hold_ch = int'(out_ch);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_y", int'(out_y), hold_y);
            check("hold_ch", int'(out_ch), hold_ch);
            check("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", int'(out_valid), 0);
        check("release_busy", int'(busy), 0);
        check("release_in_ready", int'(in_ready), 1);

        // Interleaved ch2 (coef -1.0) and ch3 (coef 0)
        cfg(2, -4, 1'b1, 1'b0);
        sample(2, 3, 3, -4, 0);
        sample(3, 3, 3, 0, 2);
        sample(2, 3, 0, -4, 3);
        sample(3, 3, 3, 0, 3);

        // Coef write in MUL and clear in ACC on active ch0 (y_prev=7, coef=2)
        e.ch = 0;
        e.y  = 3;
        sb.push_back(e);
        accept(0, 0);
        check("cfgmul_mul_a", s4(mul_a), 2);
        cfg_we   = 1'b1;
        cfg_ch   = 2'd0;
        cfg_coef = 4'b1110;
        @(negedge clk);
        cfg_we  = 1'b0;
        cfg_clr = 1'b1;
        check("acc_mul_a_hold", s4(mul_a), 2);
        @(negedge clk);
        cfg_clr = 1'b0;
        wait_out(0);
        @(negedge clk);
        sample(0, 0, -2, -2, 3);
        check("ovf_sticky", int'(ovf), 1);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iir_mac_scheduler.md
Name: iir_mac_scheduler

Overview:
Sequencer that time-shares one 4x4 signed Baugh-Wooley multiplier across CH independent first-order IIR channels, computing y[n] = x[n] + ((a * y[n-1]) >>> FRAC).
- Accepts tagged input samples over a valid/ready handshake.
- Drives the external multiplier through mul_a, mul_b and mul_p.
- Keeps per-channel coefficient and state registers.
- Returns results over a valid/ready output handshake.
- Sits between the Wishbone/LA glue and the baugh_mult datapath inside user_proj_example.

Parameters:
CH, 4, number of IIR channels (2..16)
CHW, $clog2(CH), channel index width
FRAC, 2, coefficient fraction bits (coefficient is signed Q(3-FRAC).FRAC)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  scheduler can accept a sample
in_ch  in  CHW  channel of the input sample
in_x  in  4  signed input sample
cfg_we  in  1  write the coefficient of cfg_ch
cfg_clr  in  1  clear the state y_prev of cfg_ch
cfg_ch  in  CHW  configuration channel
cfg_coef  in  4  signed coefficient
mul_a  out  4  multiplier operand: coefficient
mul_b  out  4  multiplier operand: y_prev
mul_p  in  8  signed product from baugh_mult (combinational)
out_valid  out  1  result valid
out_ready  in  1  result consumer ready
out_ch  out  CHW  channel of the result
out_y  out  4  signed result
busy  out  1  high in any state other than IDLE
ovf  out  1  sticky flag: a result overflowed 4 bits

Behaviour:
- Reset values: state IDLE; all coefficients 0; all y_prev 0; out_valid 0; out_ch 0; out_y 0; ovf 0; mul_a 0; mul_b 0; in_ready 1.
- FSM states: IDLE, MUL, ACC, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch in_ch and in_x, then go to MUL.
- MUL:
  - Drive mul_a = coef[ch] and mul_b = y_prev[ch].
  - Register mul_p into p_q at the clock edge, then go to ACC.
  - mul_a and mul_b hold their values in ACC and OUT. They return to 0 in IDLE.
- ACC:
  - Compute sum = sext5(x) + sext5(p_q >>> FRAC), using the low 5 bits of the arithmetic shift.
  - Produce res4 from sum (wrap or saturate, see Optional Feature).
  - Write y_prev[ch] = res4 and out_y = res4, assert out_valid, then go to OUT.
  - Set ovf if sum does not fit in signed 4 bits.
- OUT:
  - Hold out_valid, out_ch and out_y stable until out_ready.
  - On out_ready: deassert out_valid and return to IDLE.
  - If out_valid and out_ready are already both high on entry, the handshake completes on the next edge.
- Latency: accept edge to out_valid = 2 cycles; minimum sample period = 4 cycles with out_ready held high.
- No back-to-back accept: in_ready = 0 in MUL, ACC and OUT.
- Configuration writes are legal in any state and take effect on the next edge.
- A cfg_we to the active channel during MUL: the product uses the old coefficient, and the new value applies to the next sample.
- A cfg_clr to the active channel during MUL or ACC: the ACC write-back takes priority, so y_prev[ch] = res4.
- cfg_we and cfg_clr in the same cycle both take effect.
- ovf clears only on reset.
- in_ch or cfg_ch >= CH: the sample is accepted and dropped (no output, no state change); the configuration write is ignored.
- rst_n asserted mid-operation: immediate return to the reset values, and any in-flight result is lost.

Optional Feature:
IIR_SAT_EN
- Defined: res4 saturates sum to the range [-8, +7]; ovf still sets.
- Undefined: res4 = sum[3:0] (two's complement wrap); ovf still sets.

Decomposition:
- Package iir_sched_pkg holds:
  - localparams DW=4 and PW=8.
  - The FSM state enum {IDLE, MUL, ACC, OUT}.
  - A function sat4(sum5) and a function fits4(sum5).
- Sub-module iir_state_bank holds the CH-entry coefficient and y_prev register file:
  - Async-reset flops.
  - One config write port and one state write port (state write wins over clear).
  - Combinational read by channel.
- baugh_mult is instantiated at the top level, not inside this block.

Test Plan:
- Reset then idle: check in_ready=1, out_valid=0, busy=0 and ovf=0. Assert rst_n low during MUL: outputs return to the reset values immediately.
- Set ch0 coef=2 (0.5), then send x=4 four times with out_ready=1. Required outputs: 4, 6, 7, 7, with mul_b showing 0, 4, 6, 7.
- ch1 coef=7, y_prev=4, x=4 (sum 11):
  - With IIR_SAT_EN: out_y=7 and ovf=1.
  - Without IIR_SAT_EN: out_y=-5 (4'b1011) and ovf=1.
- Hold out_ready=0 for 5 cycles after out_valid: out_y, out_ch and out_valid stay stable, and in_ready stays 0. Raise out_ready: IDLE on the next edge.
- Interleave ch2 (coef=-4, i.e. -1.0) and ch3 (coef=0) with x=3 each:
  - ch2 outputs 3, then 0.
  - ch3 outputs 3, then 3.
  - Each channel's state stays isolated from the other.
- cfg_we to ch0 changing coef 2→-2 during MUL of a ch0 sample: the current product uses 2. cfg_clr to ch0 in ACC: y_prev equals the new result, not 0.
